// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one column low at a time, debounces a single
// pressed key and emits one pulse per press with its index and BCD digit.
module keypad_scanner #(
  parameter int CLKS_PER_COL  = 250,
  parameter int DEBOUNCE_CLKS = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Rows,
  output logic [3:0] o_Cols,
  output logic       o_Key_Valid,
  output logic [3:0] o_Key_Code,
  output logic       o_Is_Digit,
  output logic [3:0] o_Digit,
  output logic       o_Key_Held
);

  localparam int CNT_MAX = (CLKS_PER_COL > DEBOUNCE_CLKS) ? CLKS_PER_COL : DEBOUNCE_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(CLKS_PER_COL - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CLKS - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       lat_rows_q, lat_rows_d;
  logic [3:0]       rows_p0;
  logic [3:0]       r_Rows;
  logic             key_valid_d;
  logic [3:0]       key_code_d;
  logic             is_digit_d;
  logic [3:0]       digit_d;
  logic             held_d;

  // Exactly one active-low row: anything else is idle, ghosting or a multi-press.
  function automatic logic one_row_low(input logic [3:0] rows);
    case (rows)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: one_row_low = 1'b1;
      default:                            one_row_low = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] rows);
    case (rows)
      4'b1101: row_index = 2'd1;
      4'b1011: row_index = 2'd2;
      4'b0111: row_index = 2'd3;
      default: row_index = 2'd0;
    endcase
  endfunction

  // Returns {is_digit, bcd} for the telephone-style layout 123A/456B/789C/*0#D.
  function automatic logic [4:0] decode_key(input logic [3:0] code);
    case (code)
      4'd0:    decode_key = {1'b1, 4'd1};
      4'd1:    decode_key = {1'b1, 4'd2};
      4'd2:    decode_key = {1'b1, 4'd3};
      4'd4:    decode_key = {1'b1, 4'd4};
      4'd5:    decode_key = {1'b1, 4'd5};
      4'd6:    decode_key = {1'b1, 4'd6};
      4'd8:    decode_key = {1'b1, 4'd7};
      4'd9:    decode_key = {1'b1, 4'd8};
      4'd10:   decode_key = {1'b1, 4'd9};
      4'd13:   decode_key = {1'b1, 4'd0};
      default: decode_key = {1'b0, 4'd0};
    endcase
  endfunction

  // Stage p0/p1: two-flop synchronizer on the asynchronous row inputs
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      rows_p0 <= 4'b1111;
      r_Rows  <= 4'b1111;
    end else begin
      rows_p0 <= i_Rows;
      r_Rows  <= rows_p0;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    lat_rows_d  = lat_rows_q;
    key_valid_d = 1'b0;
    key_code_d  = o_Key_Code;
    is_digit_d  = o_Is_Digit;
    digit_d     = o_Digit;
    held_d      = o_Key_Held;
    case (state_q)
      SCAN: begin
        if (cnt_q == COL_LAST) begin
          cnt_d = '0;
          if (one_row_low(r_Rows)) begin
            lat_rows_d = r_Rows;
            state_d    = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (r_Rows == lat_rows_q) begin
          if (cnt_q == DEB_LAST) begin
            key_valid_d             = 1'b1;
            key_code_d              = {row_index(lat_rows_q), col_q};
            {is_digit_d, digit_d}   = decode_key({row_index(lat_rows_q), col_q});
            held_d                  = 1'b1;
            cnt_d                   = '0;
            state_d                 = HELD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = SCAN;
        end
      end
      HELD: begin
        // Column stays parked, so keys on other columns are invisible until release.
        if (r_Rows == 4'b1111) begin
          if (cnt_q == DEB_LAST) begin
            held_d  = 1'b0;
            cnt_d   = '0;
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = SCAN;
      end
    endcase
  end

  // Stage p2: FSM state and registered outputs
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= SCAN;
      col_q       <= 2'd0;
      cnt_q       <= '0;
      lat_rows_q  <= 4'b1111;
      o_Key_Valid <= 1'b0;
      o_Key_Code  <= 4'd0;
      o_Is_Digit  <= 1'b0;
      o_Digit     <= 4'd0;
      o_Key_Held  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      lat_rows_q  <= lat_rows_d;
      o_Key_Valid <= key_valid_d;
      o_Key_Code  <= key_code_d;
      o_Is_Digit  <= is_digit_d;
      o_Digit     <= digit_d;
      o_Key_Held  <= held_d;
    end
  end

  assign o_Cols = ~(4'b0001 << col_q);

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

  logic       i_Clk   = 1'b0;
  logic       i_Reset = 1'b1;
  logic [3:0] i_Rows;
  logic [3:0] o_Cols;
  logic       o_Key_Valid;
  logic [3:0] o_Key_Code;
  logic       o_Is_Digit;
  logic [3:0] o_Digit;
  logic       o_Key_Held;

  logic [15:0] keys = 16'h0000;
  int          pulses = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  keypad_scanner #(.CLKS_PER_COL(4), .DEBOUNCE_CLKS(8)) dut (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .i_Rows      (i_Rows),
    .o_Cols      (o_Cols),
    .o_Key_Valid (o_Key_Valid),
    .o_Key_Code  (o_Key_Code),
    .o_Is_Digit  (o_Is_Digit),
    .o_Digit     (o_Digit),
    .o_Key_Held  (o_Key_Held)
  );

  always #5 i_Clk = ~i_Clk;

  // Key (r,c) pulls row r low whenever column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++)
      i_Rows[r] = ~|(keys[r*4 +: 4] & ~o_Cols);
  end

  always @(posedge i_Clk) begin
    #2;
    if (o_Key_Valid) pulses++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    else
      n_pass++;
  endtask

  task automatic wait_pulses(input string tag, input int target, input int bound);
    int i = 0;
    while (pulses < target && i < bound) begin
      @(negedge i_Clk);
      i++;
    end
    check(tag, pulses, target);
    @(negedge i_Clk);
    check({tag, "_one_cycle"}, o_Key_Valid, 0);
  endtask

  task automatic wait_release(input string tag);
    int i = 0;
    while (o_Key_Held && i < 40) begin
      @(negedge i_Clk);
      i++;
    end
    check(tag, o_Key_Held, 0);
  endtask

  task automatic wait_cols(input string tag, input logic [3:0] target);
    int i = 0;
    while (o_Cols !== target && i < 40) begin
      @(negedge i_Clk);
      i++;
    end
    check(tag, o_Cols, target);
  endtask

  initial begin
    logic [3:0] exp_cols [4];
    logic [3:0] prev;
    exp_cols[0] = 4'b1101;
    exp_cols[1] = 4'b1011;
    exp_cols[2] = 4'b0111;
    exp_cols[3] = 4'b1110;

    // Reset values and idle column rotation
    repeat (3) @(negedge i_Clk);
    check("rst_cols", o_Cols, 4'b1110);
    check("rst_valid", o_Key_Valid, 0);
    check("rst_code", o_Key_Code, 0);
    check("rst_isdig", o_Is_Digit, 0);
    check("rst_digit", o_Digit, 0);
    check("rst_held", o_Key_Held, 0);
    i_Reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      repeat (4) @(negedge i_Clk);
      check($sformatf("scan_col%0d", k), o_Cols, exp_cols[k]);
    end
    check("idle_no_pulse", pulses, 0);

    // '5' pressed and released
    keys[5] = 1'b1;
    wait_pulses("k5_pulse", 1, 200);
    check("k5_code", o_Key_Code, 5);
    check("k5_isdig", o_Is_Digit, 1);
    check("k5_digit", o_Digit, 5);
    check("k5_held", o_Key_Held, 1);
    repeat (20) @(negedge i_Clk);
    check("k5_no_repeat", pulses, 1);
    keys = 16'h0000;
    repeat (5) @(negedge i_Clk);
    check("k5_held_during_release", o_Key_Held, 1);
    wait_release("k5_release");
    prev = o_Cols;
    repeat (4) @(negedge i_Clk);
    check("k5_scan_resumes", (o_Cols != prev), 1);

    // A press shorter than the debounce window is rejected
    keys[5] = 1'b1;
    repeat (6) @(negedge i_Clk);
    keys = 16'h0000;
    repeat (40) @(negedge i_Clk);
    check("short_press", pulses, 1);

    // '0' with contact bounce, then stable
    for (int i = 0; i < 6; i++) begin
      keys[13] = ~keys[13];
      @(negedge i_Clk);
    end
    check("k0_bounce_no_pulse", pulses, 1);
    keys[13] = 1'b1;
    wait_pulses("k0_pulse", 2, 200);
    check("k0_code", o_Key_Code, 13);
    check("k0_isdig", o_Is_Digit, 1);
    check("k0_digit", o_Digit, 0);
    repeat (20) @(negedge i_Clk);
    check("k0_single", pulses, 2);
    keys = 16'h0000;
    wait_release("k0_release");

    // Two rows on column 2 at once: ghost/multi, ignored
    keys[2]  = 1'b1;
    keys[10] = 1'b1;
    repeat (60) @(negedge i_Clk);
    check("multi_no_pulse", pulses, 2);
    check("multi_code_kept", o_Key_Code, 13);
    check("multi_not_held", o_Key_Held, 0);
    keys = 16'h0000;
    repeat (20) @(negedge i_Clk);

    // '#' held long, '1' pressed meanwhile
    keys[14] = 1'b1;
    wait_pulses("hash_pulse", 3, 200);
    check("hash_code", o_Key_Code, 14);
    check("hash_isdig", o_Is_Digit, 0);
    check("hash_digit", o_Digit, 0);
    repeat (100) @(negedge i_Clk);
    check("hash_no_repeat", pulses, 3);
    keys[0] = 1'b1;
    repeat (30) @(negedge i_Clk);
    check("k1_ignored", pulses, 3);
    check("k1_ignored_code", o_Key_Code, 14);
    keys[14] = 1'b0;
    wait_pulses("k1_pulse", 4, 200);
    check("k1_code", o_Key_Code, 0);
    check("k1_isdig", o_Is_Digit, 1);
    check("k1_digit", o_Digit, 1);
    keys = 16'h0000;
    wait_release("k1_release");

    // Reset in the middle of debouncing '9'
    wait_cols("k9_sync_col0", 4'b1110);
    keys[10] = 1'b1;
    wait_cols("k9_col2", 4'b1011);
    repeat (6) @(negedge i_Clk);
    i_Reset = 1'b1;
    #1;
    check("mid_rst_cols", o_Cols, 4'b1110);
    check("mid_rst_valid", o_Key_Valid, 0);
    check("mid_rst_code", o_Key_Code, 0);
    check("mid_rst_isdig", o_Is_Digit, 0);
    check("mid_rst_digit", o_Digit, 0);
    check("mid_rst_held", o_Key_Held, 0);
    repeat (3) @(negedge i_Clk);
    check("mid_rst_no_pulse", pulses, 4);
    i_Reset = 1'b0;
    wait_pulses("k9_pulse", 5, 200);
    check("k9_code", o_Key_Code, 10);
    check("k9_isdig", o_Is_Digit, 1);
    check("k9_digit", o_Digit, 9);
    keys = 16'h0000;
    wait_release("k9_release");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
